// File: rtl/dsp_fractured_accum_unpacker.sv
// dsp_fractured_accum_unpacker
//   Captures packed {f1, f2} accumulator words into a small FIFO, narrows each
//   signed 32-bit lane to OUT_WIDTH bits (optional saturation) and serializes
//   f1 then f2 onto a valid/ready stream.
//
// Optional feature macro: DSP_UNPACK_STICKY_SAT_EN (adds sticky_sat_o).
//
// Ports:
//   clk, reset        clock, async active-high reset
//   p_i[63:0]         packed word, [63:32]=f1, [31:0]=f2 (signed)
//   p_valid_i         p_i valid (no backpressure toward the source)
//   sat_en_i          saturate (1) / truncate (0), stored with the word
//   m_data_o          current output lane (signed, OUT_WIDTH bits)
//   m_lane_o          0 = f1, 1 = f2
//   m_sat_o           current lane was clamped
//   m_valid_o         output beat valid
//   m_ready_i         downstream accepts the beat
//   drop_o            one-cycle pulse after an input word was discarded
//   sticky_sat_o      (macro only) set on any accepted clamped beat
module dsp_fractured_accum_unpacker #(
  parameter int OUT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [63:0]          p_i,
  input  logic                 p_valid_i,
  input  logic                 sat_en_i,
  output logic [OUT_WIDTH-1:0] m_data_o,
  output logic                 m_lane_o,
  output logic                 m_sat_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic                 drop_o
`ifdef DSP_UNPACK_STICKY_SAT_EN
  ,output logic                sticky_sat_o
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic signed [63:0] MAXV = (64'sd1 <<< (OUT_WIDTH-1)) - 64'sd1;
  localparam logic signed [63:0] MINV = -(64'sd1 <<< (OUT_WIDTH-1));
  localparam logic [OUT_WIDTH-1:0] MAX_O = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MIN_O = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [63:0] p;
    logic        sat_en;
  } entry_t;

  typedef enum logic [1:0] {IDLE, LANE1, LANE2} state_t;

  // Returns {sat, data}. With OUT_WIDTH=32 the clamp limits equal the
  // 32-bit range, so the value passes through and sat never sets.
  function automatic logic [OUT_WIDTH:0] f_narrow(input logic [31:0] v,
                                                  input logic sat_en);
    logic signed [63:0] vx;
    vx = $signed({{32{v[31]}}, v});
    if (sat_en && (vx > MAXV))      return {1'b1, MAX_O};
    else if (sat_en && (vx < MINV)) return {1'b1, MIN_O};
    else                            return {1'b0, v[OUT_WIDTH-1:0]};
  endfunction

  // ---------------- FIFO ----------------
  entry_t        r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_empty, w_full, w_push, w_pop;
  entry_t        w_head;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_head  = r_mem[r_rptr];
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push  = p_valid_i & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= '{p: p_i, sat_en: sat_en_i};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // ---------------- lane narrowing ----------------
  logic [1:0][OUT_WIDTH-1:0] w_nar_data;
  logic [1:0]                w_nar_sat;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [OUT_WIDTH:0] w_res;
    // lane 0 = f1 (upper half), lane 1 = f2 (lower half)
    assign w_res         = f_narrow(w_head.p[63-32*g -: 32], w_head.sat_en);
    assign w_nar_data[g] = w_res[OUT_WIDTH-1:0];
    assign w_nar_sat[g]  = w_res[OUT_WIDTH];
  end

  // ---------------- FSM ----------------
  state_t r_state, w_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = LANE1;
        end
      end
      LANE1: begin
        if (m_ready_i) w_next = LANE2;
      end
      LANE2: begin
        if (m_ready_i) begin
          if (!w_empty) begin
            w_pop  = 1'b1;
            w_next = LANE1;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // ---------------- output registers ----------------
  // Both lanes are narrowed at pop time; f2 waits in r_f2_* until f1 leaves.
  logic [OUT_WIDTH-1:0] r_data, r_f2_data;
  logic                 r_lane, r_sat, r_f2_sat, r_valid, r_drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data    <= '0;
      r_lane    <= 1'b0;
      r_sat     <= 1'b0;
      r_valid   <= 1'b0;
      r_f2_data <= '0;
      r_f2_sat  <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_drop <= p_valid_i & ~w_push;
      if (w_pop) begin
        r_data    <= w_nar_data[0];
        r_sat     <= w_nar_sat[0];
        r_lane    <= 1'b0;
        r_valid   <= 1'b1;
        r_f2_data <= w_nar_data[1];
        r_f2_sat  <= w_nar_sat[1];
      end else if (r_state == LANE1 && m_ready_i) begin
        r_data <= r_f2_data;
        r_sat  <= r_f2_sat;
        r_lane <= 1'b1;
      end else if (r_state == LANE2 && m_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign m_data_o  = r_data;
  assign m_lane_o  = r_lane;
  assign m_sat_o   = r_sat;
  assign m_valid_o = r_valid;
  assign drop_o    = r_drop;

`ifdef DSP_UNPACK_STICKY_SAT_EN
  logic r_sticky_sat;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              r_sticky_sat <= 1'b0;
    else if (r_valid && m_ready_i && r_sat) r_sticky_sat <= 1'b1;
  end
  assign sticky_sat_o = r_sticky_sat;
`endif

endmodule
